// File: rtl/hazard_ctrl.sv
// Load-use / MDU interlock and branch-flush controller for the 5-stage core.
// Controls are combinational from state and inputs; the MDU tracker and stall counter update on the edge.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_is_mdu,
    input  logic        id_reads_hilo,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_num_write,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_cycles
);

    localparam int CW = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   stall_cycles_q, stall_cycles_d;

    logic load_hz;
    logic mdu_hz;
    logic stall;

    always_comb begin
        load_hz = ex_mem_read && ex_reg_write && (ex_num_write != 5'd0) &&
                  ((id_rs == ex_num_write) || (id_uses_rt && (id_rt == ex_num_write)));
        mdu_hz  = (state_q == MDU_BUSY) && (id_is_mdu || id_reads_hilo);
        stall   = (load_hz || mdu_hz) && !branch_taken;
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mdu_start  = 1'b0;
        // A taken branch makes the ID instruction wrong-path, so its stall is dropped.
        if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            mdu_start  = id_is_mdu && (state_q == RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mdu_start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            MDU_BUSY: begin
                // The MDU op is older than any branch, so a flush never cancels it.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mdu_busy     = (state_q == MDU_BUSY);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the outputs of that cycle.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_num_write = '0;
    logic        id_uses_rt = 1'b0, id_is_mdu = 1'b0, id_reads_hilo = 1'b0;
    logic        ex_mem_read = 1'b0, ex_reg_write = 1'b0, branch_taken = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, mdu_start, mdu_busy;
    logic [15:0] stall_cycles;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string       name;
        logic [5:0]  ctl;   // {pc_en, ifid_en, ifid_flush, idex_flush, mdu_start, mdu_busy}
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];

    hazard_ctrl #(.MDU_LATENCY(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_is_mdu     (id_is_mdu),
        .id_reads_hilo (id_reads_hilo),
        .ex_mem_read   (ex_mem_read),
        .ex_reg_write  (ex_reg_write),
        .ex_num_write  (ex_num_write),
        .branch_taken  (branch_taken),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .mdu_start     (mdu_start),
        .mdu_busy      (mdu_busy),
        .stall_cycles  (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got ctl=%b sc=%h, expected ctl=%b sc=%h",
                     name, got[21:16], got[15:0], want[21:16], want[15:0]);
        end
    endtask

    task automatic step(input string name,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mdu, input logic hilo, input logic mr, input logic rw,
                        input logic [4:0] wn, input logic bt,
                        input logic [5:0] ctl, input logic [15:0] sc);
        exp_t e;
        @(posedge clock);
        #1;
        id_rs = rs; id_rt = rt; id_uses_rt = urt; id_is_mdu = mdu; id_reads_hilo = hilo;
        ex_mem_read = mr; ex_reg_write = rw; ex_num_write = wn; branch_taken = bt;
        e.name = name; e.ctl = ctl; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [5:0] ctl, input logic [15:0] sc);
        step(name, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, ctl, sc);
    endtask

    // Monitor: compares the outputs of each cycle that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name,
                      {pc_en, ifid_en, ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cycles},
                      {e.ctl, e.sc});
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state and load-use on rs
        idle("idle", 6'b110000, 16'd0);
        step("ld_use_rs", 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 6'b000100, 16'd0);
        idle("ld_use_rel", 6'b110000, 16'd1);
        step("ld_r0", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 6'b110000, 16'd1);
        step("ld_use_rt", 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 6'b000100, 16'd1);
        step("ld_rt_unused", 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 6'b110000, 16'd2);
        step("ld_no_wr", 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 6'b110000, 16'd2);

        // mult then mfhi: 8 busy/stall cycles, release at t+9
        step("mdu_start", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110010, 16'd2);
        for (int i = 0; i < 8; i++)
            step("mfhi_stall", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0,
                 6'b000101, 16'(2 + i));
        step("mfhi_go", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110000, 16'd10);

        // Back-to-back MDU ops, with a branch during the second busy period
        step("mdu_a", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110010, 16'd10);
        for (int i = 0; i < 8; i++)
            step("mdu_b_stall", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0,
                 6'b000101, 16'(10 + i));
        step("mdu_b_start", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110010, 16'd18);
        idle("mdu_b_busy", 6'b110001, 16'd18);
        step("br_in_busy", 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 6'b111101, 16'd18);
        for (int i = 0; i < 6; i++)
            idle("mdu_b_busy", 6'b110001, 16'd18);
        idle("mdu_b_done", 6'b110000, 16'd18);

        // Branch beats load-use and an MDU start
        step("br_prio", 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 6'b111100, 16'd18);
        idle("br_after", 6'b110000, 16'd18);

        // Reset in the middle of a busy period
        step("mdu_c", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110010, 16'd18);
        idle("mdu_c_busy", 6'b110001, 16'd18);
        idle("mdu_c_busy", 6'b110001, 16'd18);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check("async_rst",
                 {pc_en, ifid_en, ifid_flush, idex_flush, mdu_start, mdu_busy, stall_cycles},
                 {6'b110000, 16'd0});
        @(posedge clock);
        #1 reset = 1'b0;
        begin
            exp_t e;
            e.name = "post_rst"; e.ctl = 6'b110000; e.sc = 16'd0;
            exp_q.push_back(e);
        end
        step("restart", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 6'b110010, 16'd0);
        for (int i = 0; i < 8; i++)
            idle("restart_busy", 6'b110001, 16'd0);
        idle("restart_done", 6'b110000, 16'd0);

        // Saturation: hold a load-use stall far past 65535 cycles
        step("sat_begin", 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 6'b000100, 16'd0);
        repeat (70000) @(posedge clock);
        step("sat_hold", 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 6'b000100, 16'hFFFF);
        idle("sat_idle", 6'b110000, 16'hFFFF);
        idle("sat_idle2", 6'b110000, 16'hFFFF);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        check("queue_drained", 22'(exp_q.size()), 22'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
